inv_mix_columns_serial: RTL and testbench
=========================================

// Module: inv_mix_columns_serial
// PURPOSE
//  Byte-serial AES InvMixColumns stage of the decryption round datapath. It sits directly
//  upstream of invShiftRows (AddRoundKey -> InvMixColumns -> InvShiftRows) and feeds its inbyte.
//  It accepts a column-major state stream of one byte per valid cycle, gathers each 4-byte column,
//  transforms it in GF(2^8), and re-emits it as 4 registered bytes, one per clock.
// PARAMETERS
//  ENABLE_BYPASS  1  1: bypass input honoured (final inverse round); 0: bypass ignored, always transform
// PORTS
//  clock     input   1  rising-edge clock
//  resetn    input   1  asynchronous active-low reset
//  inbyte    input   8  state byte, column-major order s00,s10,s20,s30,s01,...,s33
//  in_valid  input   1  inbyte valid this cycle
//  bypass    input   1  sampled with byte 0 of each column; 1 = pass column unchanged
//  outbyte   output  8  transformed byte, same column-major order
//  ready     output  1  outbyte valid this cycle
//  last      output  1  high with the final byte (s33) of each 16-byte block
// BEHAVIOUR
//  Reset (async, resetn=0): outbyte=8'h00, ready=0, last=0. Byte counter, column counter,
//   column buffer, output buffer and bypass flag are cleared. A partial column or block is
//   discarded. The first valid byte after release is s00 of a new block.
//  Input side: 2-bit byte counter b advances only on in_valid=1. Bytes 0..2 are stored in
//   col_reg. When b==0, bypass is also latched into byp_col (forced 0 if ENABLE_BYPASS=0).
//   in_valid=0 stalls accumulation with no loss.
//  Column completion is the clock edge K at which byte 3 is sampled. The result is computed
//   combinationally from col_reg[0..2] and inbyte as a0..a3, with no extra register stage.
//   r0=0e*a0^0b*a1^0d*a2^09*a3   r1=09*a0^0e*a1^0b*a2^0d*a3
//   r2=0d*a0^09*a1^0e*a2^0b*a3   r3=0b*a0^0d*a1^09*a2^0e*a3
//   Multiplication is in GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11b), built from xtime chains.
//   If byp_col=1, r=a.
//  Output side: at edge K, r0..r3 are loaded into a 4-byte output shift buffer.
//   outbyte=r0, ready=1 after K. outbyte=r1, r2, r3 after K+1, K+2, K+3.
//   The 2-bit emit counter then expires.
//   At edge K+4, if another column completes, its r0 follows with no bubble. Otherwise ready=0.
//   outbyte holds its last value whenever ready=0.
//  Latency: the first output byte is visible 1 cycle after the column's 4th input byte.
//   A gap-free input stream therefore gives a gap-free output stream: 16 bytes in, 16 bytes out.
//   Overlap is impossible because each column takes at least 4 input cycles, so there is
//   no overflow and no backpressure.
//  Simultaneous events: a completion on the same edge as the previous column's 4th emit
//   reloads the buffer. Emission continues while in_valid toggles.
//  Column counter c (0..3) advances at each column completion and wraps 3->0.
//   last=1 only while emitting r3 of column c==3.
// TESTING
//  1 FIPS column: 9f dc 58 9d, in_valid held high -> ready high 4 cycles starting 1 cycle
//    after the 4th byte; outbyte f2 0a 22 5c.
//  2 Inverse of known MixColumns: 8e 4d a1 bc -> db 13 53 45. d5 d5 d7 d6 -> d4 d4 d4 d5.
//    01 01 01 01 -> 01 01 01 01. c6 c6 c6 c6 -> c6 c6 c6 c6.
//  3 Full 16-byte block, continuous, made of the 4 columns of test 2 -> 16 contiguous ready
//    cycles with correct bytes. last=1 only on the 16th output byte (45 slot of column 3 = c6).
//  4 Gapped input: 9f, gap, dc, 2-cycle gap, 58, 9d -> identical output f2 0a 22 5c.
//    ready is low until the cycle after 9d.
//  5 bypass=1 with byte 0 of column 9f dc 58 9d -> output 9f dc 58 9d.
//    The next column with bypass=0 is transformed. With ENABLE_BYPASS=0 the column transforms anyway.
//  6 Assert resetn low after 2 bytes of a column and during an emission -> outputs go 0 immediately.
//    After release, 8e 4d a1 bc -> db 13 53 45 with no stale data, and last aligns to the new block.

Source files
------------

// File: rtl/inv_mix_columns_serial.sv
// rtl/inv_mix_columns_serial.sv - byte-serial AES InvMixColumns stage
//
// Gathers a column-major AES state stream one byte per valid cycle, applies
// InvMixColumns to each completed 4-byte column and re-emits the result as
// four registered bytes, one per clock, starting the cycle after byte 3.
//
// Ports:
//   clock     rising-edge clock
//   resetn    asynchronous active-low reset
//   inbyte    state byte, column-major order s00,s10,s20,s30,s01,...,s33
//   in_valid  inbyte valid this cycle
//   bypass    sampled with byte 0 of each column; 1 = pass column unchanged
//   outbyte   transformed byte, same column-major order
//   ready     outbyte valid this cycle
//   last      high with the final byte (s33) of each 16-byte block
module inv_mix_columns_serial #(
  parameter logic ENABLE_BYPASS = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] inbyte,
  input  logic       in_valid,
  input  logic       bypass,
  output logic [7:0] outbyte,
  output logic       ready,
  output logic       last
);

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e) via an xtime chain.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  logic [1:0]  b_q, b_d;          // input byte index within column
  logic [1:0]  c_q, c_d;          // column index within block
  logic [1:0]  e_q, e_d;          // index of the byte currently on outbyte
  logic [7:0]  col0_q, col0_d;
  logic [7:0]  col1_q, col1_d;
  logic [7:0]  col2_q, col2_d;
  logic        byp_q, byp_d;
  logic        lastcol_q, lastcol_d; // column being emitted is column 3
  logic [23:0] sb_q, sb_d;        // pending r1,r2,r3
  logic [7:0]  out_q, out_d;
  logic        ready_q, ready_d;
  logic        last_q, last_d;

  logic        done;
  logic [7:0]  a3, r0, r1, r2, r3;

  always_comb begin
    b_d       = b_q;
    c_d       = c_q;
    e_d       = e_q;
    col0_d    = col0_q;
    col1_d    = col1_q;
    col2_d    = col2_q;
    byp_d     = byp_q;
    lastcol_d = lastcol_q;
    sb_d      = sb_q;
    out_d     = out_q;
    ready_d   = ready_q;
    last_d    = last_q;

    done = in_valid && (b_q == 2'd3);
    a3   = inbyte;

    if (in_valid) begin
      b_d = b_q + 2'd1;
      case (b_q)
        2'd0: begin
          col0_d = inbyte;
          byp_d  = bypass & ENABLE_BYPASS;
        end
        2'd1:    col1_d = inbyte;
        2'd2:    col2_d = inbyte;
        default: ;
      endcase
    end

    r0 = gm(col0_q, 4'he) ^ gm(col1_q, 4'hb) ^ gm(col2_q, 4'hd) ^ gm(a3, 4'h9);
    r1 = gm(col0_q, 4'h9) ^ gm(col1_q, 4'he) ^ gm(col2_q, 4'hb) ^ gm(a3, 4'hd);
    r2 = gm(col0_q, 4'hd) ^ gm(col1_q, 4'h9) ^ gm(col2_q, 4'he) ^ gm(a3, 4'hb);
    r3 = gm(col0_q, 4'hb) ^ gm(col1_q, 4'hd) ^ gm(col2_q, 4'h9) ^ gm(a3, 4'he);
    if (byp_q) begin
      r0 = col0_q;
      r1 = col1_q;
      r2 = col2_q;
      r3 = a3;
    end

    // A completion can only coincide with the last emit of the previous
    // column (or an idle output), so it always wins and reloads the buffer.
    if (done) begin
      out_d     = r0;
      sb_d      = {r1, r2, r3};
      e_d       = 2'd0;
      ready_d   = 1'b1;
      last_d    = 1'b0;
      lastcol_d = (c_q == 2'd3);
      c_d       = c_q + 2'd1;
    end else if (ready_q) begin
      if (e_q == 2'd3) begin
        ready_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        out_d  = sb_q[23:16];
        sb_d   = {sb_q[15:0], 8'h00};
        e_d    = e_q + 2'd1;
        last_d = lastcol_q && (e_q == 2'd2);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      b_q       <= 2'd0;
      c_q       <= 2'd0;
      e_q       <= 2'd0;
      col0_q    <= 8'h00;
      col1_q    <= 8'h00;
      col2_q    <= 8'h00;
      byp_q     <= 1'b0;
      lastcol_q <= 1'b0;
      sb_q      <= 24'h0;
      out_q     <= 8'h00;
      ready_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      b_q       <= b_d;
      c_q       <= c_d;
      e_q       <= e_d;
      col0_q    <= col0_d;
      col1_q    <= col1_d;
      col2_q    <= col2_d;
      byp_q     <= byp_d;
      lastcol_q <= lastcol_d;
      sb_q      <= sb_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      last_q    <= last_d;
    end
  end

  assign outbyte = out_q;
  assign ready   = ready_q;
  assign last    = last_q;

endmodule

// File: tb/tb_inv_mix_columns_serial.sv
// tb/tb_inv_mix_columns_serial.sv - scoreboard bench for inv_mix_columns_serial
module tb_inv_mix_columns_serial;

  typedef struct {
    logic [7:0] b;
    logic       l;
    int         t;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] inbyte = 8'h00;
  logic       in_valid = 1'b0;
  logic       bypass = 1'b0;
  logic [7:0] out1, out0;
  logic       rdy1, rdy0, last1, last0;

  int   edge_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   col_n = 0;
  exp_t q1[$];
  exp_t q0[$];

  inv_mix_columns_serial #(.ENABLE_BYPASS(1'b1)) dut1 (
    .clock(clock), .resetn(resetn), .inbyte(inbyte), .in_valid(in_valid),
    .bypass(bypass), .outbyte(out1), .ready(rdy1), .last(last1)
  );

  inv_mix_columns_serial #(.ENABLE_BYPASS(1'b0)) dut0 (
    .clock(clock), .resetn(resetn), .inbyte(inbyte), .in_valid(in_valid),
    .bypass(bypass), .outbyte(out0), .ready(rdy0), .last(last0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Reference: GF(2^8) multiply by shift-and-add with reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int aa, p;
    aa = a;
    p  = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
    end
    return p[7:0];
  endfunction

  // InvMixColumns of a column packed as {a0,a1,a2,a3}: circulant row 0e 0b 0d 09.
  function automatic logic [31:0] imc(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] k [4];
    logic [7:0] r;
    logic [31:0] res;
    k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
    res = 0;
    for (int i = 0; i < 4; i++) begin
      r = 8'h00;
      for (int j = 0; j < 4; j++) r = r ^ gmul(a[j], k[(j - i + 4) % 4]);
      res[31-8*i -: 8] = r;
    end
    return res;
  endfunction

  // Drive one column; gaps holds 2-bit idle-cycle counts before each byte.
  task automatic send_col(input logic [31:0] col, input logic byp, input logic [7:0] gaps,
                          input logic [31:0] e1, input logic [31:0] e0);
    int   k;
    exp_t x;
    for (int j = 0; j < 4; j++) begin
      if (gaps[2*j +: 2] != 2'd0) begin
        in_valid = 1'b0;
        repeat (int'(gaps[2*j +: 2])) begin @(posedge clock); #1; end
      end
      inbyte   = col[31-8*j -: 8];
      bypass   = (j == 0) ? byp : 1'($urandom);
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    k = edge_cnt;
    for (int j = 0; j < 4; j++) begin
      x.l = (j == 3) && (col_n == 3);
      x.t = k + j;
      x.b = e1[31-8*j -: 8];
      q1.push_back(x);
      x.b = e0[31-8*j -: 8];
      q0.push_back(x);
    end
    col_n    = (col_n + 1) % 4;
    in_valid = 1'b0;
  endtask

  task automatic send_tx(input logic [31:0] col, input logic byp, input logic [7:0] gaps);
    logic [31:0] t;
    t = imc(col);
    send_col(col, byp, gaps, byp ? col : t, t);
  endtask

  task automatic hit_reset(input string name);
    resetn = 1'b0;
    q1.delete();
    q0.delete();
    col_n = 0;
    #1;
    chk({name, "_out1"}, {24'h0, out1}, 32'h0);
    chk({name, "_rdy1"}, {31'h0, rdy1}, 32'h0);
    chk({name, "_last1"}, {31'h0, last1}, 32'h0);
    chk({name, "_out0"}, {24'h0, out0}, 32'h0);
    chk({name, "_rdy0"}, {31'h0, rdy0}, 32'h0);
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  // Scoreboard monitors, one per DUT.
  always @(negedge clock) begin
    if (resetn) begin
      if (rdy1) begin
        if (q1.size() == 0) chk("spurious_ready1", 32'd1, 32'd0);
        else begin
          exp_t x;
          x = q1.pop_front();
          chk("byte1", {24'h0, out1}, {24'h0, x.b});
          chk("last1", {31'h0, last1}, {31'h0, x.l});
          chk("time1", edge_cnt, x.t);
        end
      end else if (q1.size() != 0 && q1[0].t < edge_cnt) begin
        chk("missed1", edge_cnt, q1[0].t);
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      if (rdy0) begin
        if (q0.size() == 0) chk("spurious_ready0", 32'd1, 32'd0);
        else begin
          exp_t x;
          x = q0.pop_front();
          chk("byte0", {24'h0, out0}, {24'h0, x.b});
          chk("last0", {31'h0, last0}, {31'h0, x.l});
          chk("time0", edge_cnt, x.t);
        end
      end else if (q0.size() != 0 && q0[0].t < edge_cnt) begin
        chk("missed0", edge_cnt, q0[0].t);
        void'(q0.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] c;
    logic [7:0]  g;
    logic        b;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_out", {24'h0, out1}, 32'h0);
    chk("reset_rdy", {31'h0, rdy1}, 32'h0);
    chk("reset_last", {31'h0, last1}, 32'h0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // FIPS column, then the known MixColumns inverses as one contiguous block.
    send_col(32'h9fdc589d, 1'b0, 8'h00, 32'hf20a225c, 32'hf20a225c);
    repeat (6) @(posedge clock);
    #1;
    col_n = 1;
    send_col(32'h9fdc589d, 1'b0, 8'h00, 32'hf20a225c, 32'hf20a225c);
    send_col(32'h8e4da1bc, 1'b0, 8'h00, 32'hdb135345, 32'hdb135345);
    send_col(32'hd5d5d7d6, 1'b0, 8'h00, 32'hd4d4d4d5, 32'hd4d4d4d5);
    send_col(32'h01010101, 1'b0, 8'h00, 32'h01010101, 32'h01010101);
    send_col(32'hc6c6c6c6, 1'b0, 8'h00, 32'hc6c6c6c6, 32'hc6c6c6c6);
    repeat (6) @(posedge clock);
    #1;

    // Gapped input: 9f, gap, dc, 2 gaps, 58, 9d.
    send_col(32'h9fdc589d, 1'b0, 8'b00_10_01_00, 32'hf20a225c, 32'hf20a225c);
    // Bypass column then a transformed one; dut0 ignores bypass.
    send_col(32'h9fdc589d, 1'b1, 8'h00, 32'h9fdc589d, 32'hf20a225c);
    send_col(32'h9fdc589d, 1'b0, 8'h00, 32'hf20a225c, 32'hf20a225c);
    repeat (6) @(posedge clock);
    #1;

    // Randomized columns with random bypass and gaps.
    for (int n = 0; n < 48; n++) begin
      c = $urandom;
      b = ($urandom_range(0, 3) == 0);
      g = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      send_tx(c, b, g);
    end
    repeat (6) @(posedge clock);
    #1;

    // Reset mid-column.
    inbyte = 8'h8e; in_valid = 1'b1;
    @(posedge clock); #1;
    inbyte = 8'h4d;
    @(posedge clock); #1;
    in_valid = 1'b0;
    hit_reset("rst_partial");

    // Reset during an emission.
    send_col(32'h9fdc589d, 1'b0, 8'h00, 32'hf20a225c, 32'hf20a225c);
    @(negedge clock); #2;
    hit_reset("rst_emit");

    // Fresh block after reset: last must land on its 16th byte.
    send_col(32'h8e4da1bc, 1'b0, 8'h00, 32'hdb135345, 32'hdb135345);
    send_col(32'hd5d5d7d6, 1'b0, 8'h00, 32'hd4d4d4d5, 32'hd4d4d4d5);
    send_col(32'h01010101, 1'b0, 8'h00, 32'h01010101, 32'h01010101);
    send_col(32'hc6c6c6c6, 1'b0, 8'h00, 32'hc6c6c6c6, 32'hc6c6c6c6);

    for (int i = 0; i < 20 && (q1.size() + q0.size()) != 0; i++) @(posedge clock);
    @(posedge clock); #1;
    chk("drain", q1.size() + q0.size(), 32'd0);
    chk("idle_rdy1", {31'h0, rdy1}, 32'h0);
    chk("idle_rdy0", {31'h0, rdy0}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
